// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and helpers for the switch/button debouncer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: db_state_t per-channel FSM state, its encodings, and db_cycles(),
// which converts a clock frequency and a hold time into a cycle count.
package debounce_pkg;

  localparam logic [1:0] ST_STABLE0_ENC = 2'd0;
  localparam logic [1:0] ST_DETECT1_ENC = 2'd1;
  localparam logic [1:0] ST_STABLE1_ENC = 2'd2;
  localparam logic [1:0] ST_DETECT0_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_STABLE0 = ST_STABLE0_ENC,
    ST_DETECT1 = ST_DETECT1_ENC,
    ST_STABLE1 = ST_STABLE1_ENC,
    ST_DETECT0 = ST_DETECT0_ENC
  } db_state_t;

  // Cycles in a window of 'us' microseconds at 'mhz' MHz.
  function automatic int unsigned db_cycles(input int unsigned mhz, input int unsigned us);
    return mhz * us;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one debouncer channel (optional 2-flop sync, FSM, hold counter).
// Latency: out/rise/fall update DB_CYCLES edges after the first differing sample (+2 with sync).
// Backpressure: none; the input is sampled every cycle.
// Ports: clk, reset_n (async active-low), in (raw level), out (clean level),
//        rise/fall (one-cycle commit pulses), pending (qualifying a change).
// Optional sync stage enabled by defining DEBOUNCE_MULTI_SYNC_EN.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 8,
  parameter int unsigned CNT_W       = 3,
  parameter bit          RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic pending
);

  localparam db_state_t        RST_STATE = RESET_LEVEL ? ST_STABLE1 : ST_STABLE0;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DB_CYCLES - 1);

  logic s;

`ifdef DEBOUNCE_MULTI_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], in};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {2{RESET_LEVEL}};
    else          sync_q <= sync_d;
  end

  assign s = sync_q[1];
`else
  assign s = in;
`endif

  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             pending_q, pending_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_STABLE0: begin
        cnt_d = '0;
        if (s) state_d = ST_DETECT1;
      end
      ST_DETECT1: begin
        if (!s) begin
          // Bounce back to the old level: abandon silently.
          state_d = ST_STABLE0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE1;
          cnt_d   = '0;
          out_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STABLE1: begin
        cnt_d = '0;
        if (!s) state_d = ST_DETECT0;
      end
      ST_DETECT0: begin
        if (s) begin
          state_d = ST_STABLE1;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE0;
          cnt_d   = '0;
          out_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
        out_d   = RESET_LEVEL;
      end
    endcase
    // Registered from the next state so pending lines up with the FSM.
    pending_d = (state_d == ST_DETECT1) || (state_d == ST_DETECT0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RST_STATE;
      cnt_q     <= '0;
      out_q     <= RESET_LEVEL;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pending_q <= pending_d;
    end
  end

  assign out     = out_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign pending = pending_q;

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: CHANNELS independent switch/button debouncers.
// Latency: DB_CYCLES edges from first differing sample to commit (+2 with DEBOUNCE_MULTI_SYNC_EN).
// Backpressure: none; every input is sampled every cycle.
// Ports: clk, reset_n (async active-low), in[CHANNELS] raw, out[CHANNELS] clean,
//        rise/fall[CHANNELS] one-cycle edge pulses, pending[CHANNELS] qualifying.
// Define DEBOUNCE_MULTI_SYNC_EN to put a 2-flop synchroniser on every input.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CLKSPDMHZ   = 100,
  parameter int unsigned DELAYUS     = 5000,
  parameter bit          RESET_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] pending
);

  localparam int unsigned DB_CYCLES = db_cycles(CLKSPDMHZ, DELAYUS);
  localparam int unsigned CNT_W     = $clog2(DB_CYCLES);

  if (DB_CYCLES < 2) begin : g_bad_cycles
    $error("debounce_multi: CLKSPDMHZ*DELAYUS must be at least 2");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("debounce_multi: CHANNELS must be at least 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_chan #(
      .DB_CYCLES  (DB_CYCLES),
      .CNT_W      (CNT_W),
      .RESET_LEVEL(RESET_LEVEL)
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .in     (in[i]),
      .out    (out[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .pending(pending[i])
    );
  end

endmodule
